// File: rtl/ps2_ascii_rx.sv
// rtl/ps2_ascii_rx.sv - PS/2 keyboard receiver with scan-code to ASCII decoding
//
// Deserialises device-to-host PS/2 frames and turns make codes into ASCII
// characters. It tracks the E0 (extended), F0 (break) and shift state.
//
// Ports:
//   clk          system/pixel clock (25 MHz)
//   rst          asynchronous active-high reset
//   ps2c, ps2d   asynchronous PS/2 clock and data from the keyboard
//   ascii        decoded character, held until the next ascii_valid
//   ascii_valid  1-cycle strobe: ascii holds a new character
//   scan_code    last good raw byte received, held
//   scan_done    1-cycle strobe: good frame received, scan_code updated
//   frame_err    1-cycle strobe: parity/stop error or mid-frame timeout
//   shift_on     either shift key currently held
module ps2_ascii_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic [7:0] ascii,
   output logic       ascii_valid,
   output logic [7:0] scan_code,
   output logic       scan_done,
   output logic       frame_err,
   output logic       shift_on
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   logic [1:0]            c_sync, d_sync;
   logic [FILTER_LEN-1:0] filt_reg;
   logic                  filt_c, fall;
   logic                  d;

   rx_state_t             state, state_next;
   logic [2:0]            bitcnt;
   logic [7:0]            shreg;
   logic                  par;
   logic [TW-1:0]         tcnt;
   logic                  timeout, frame_ok, frame_bad;

   logic                  brk, ext;
   logic [7:0]            lc, map;
   logic                  hit, letter;

   assign d = d_sync[1];

   // Input conditioning. The lines idle high, so the synchronisers and filter
   // also reset high; this keeps release from reset from looking like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_sync   <= '1;
         d_sync   <= '1;
         filt_reg <= '1;
         filt_c   <= 1'b1;
         fall     <= 1'b0;
      end else begin
         c_sync   <= {c_sync[0], ps2c};
         d_sync   <= {d_sync[0], ps2d};
         filt_reg <= {filt_reg[FILTER_LEN-2:0], c_sync[1]};
         if (&filt_reg)
            filt_c <= 1'b1;
         else if (~|filt_reg)
            filt_c <= 1'b0;
         // fall is high in the same cycle that filt_c first reads 0
         fall <= filt_c & ~|filt_reg;
      end
   end

   assign timeout = (tcnt == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !d)
               state_next = DATA;
         end
         DATA: begin
            if (fall) begin
               if (bitcnt == 3'd7)
                  state_next = PARITY;
            end else if (timeout) begin
               state_next = IDLE;
               frame_bad  = 1'b1;
            end
         end
         PARITY: begin
            if (fall) begin
               state_next = STOP;
            end else if (timeout) begin
               state_next = IDLE;
               frame_bad  = 1'b1;
            end
         end
         STOP: begin
            if (fall) begin
               state_next = IDLE;
               if (d && ^{shreg, par})
                  frame_ok = 1'b1;
               else
                  frame_bad = 1'b1;
            end else if (timeout) begin
               state_next = IDLE;
               frame_bad  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitcnt    <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         tcnt      <= '0;
         scan_code <= '0;
         scan_done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (state == IDLE || fall)
            tcnt <= '0;
         else if (!timeout)
            tcnt <= tcnt + TW'(1);
         if (state == IDLE)
            bitcnt <= '0;
         else if (state == DATA && fall)
            bitcnt <= bitcnt + 3'd1;
         if (state == DATA && fall)
            shreg <= {d, shreg[7:1]};
         if (state == PARITY && fall)
            par <= d;
         scan_done <= frame_ok;
         frame_err <= frame_bad;
         if (frame_ok)
            scan_code <= shreg;
      end
   end

   // Translation table. lc is the unshifted character (0 = unmapped).
   // Letters become upper case under shift by clearing bit 5.
   always_comb begin
      lc = 8'h00;
      case (scan_code)
         8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
         8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
         8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
         8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
         8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
         8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
         8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
         8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
         8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
         8'h45: lc = shift_on ? 8'h29 : 8'h30;
         8'h16: lc = shift_on ? 8'h21 : 8'h31;
         8'h1E: lc = shift_on ? 8'h40 : 8'h32;
         8'h26: lc = shift_on ? 8'h23 : 8'h33;
         8'h25: lc = shift_on ? 8'h24 : 8'h34;
         8'h2E: lc = shift_on ? 8'h25 : 8'h35;
         8'h36: lc = shift_on ? 8'h5E : 8'h36;
         8'h3D: lc = shift_on ? 8'h26 : 8'h37;
         8'h3E: lc = shift_on ? 8'h2A : 8'h38;
         8'h46: lc = shift_on ? 8'h28 : 8'h39;
         8'h29: lc = 8'h20;
         8'h5A: lc = 8'h0D;
         8'h66: lc = 8'h08;
         default: lc = 8'h00;
      endcase
      letter = (lc >= 8'h61) && (lc <= 8'h7A);
      hit    = (lc != 8'h00);
      map    = (letter && shift_on) ? (lc & 8'hDF) : lc;
   end

   // Decoder. E0/F0 are prefixes that only set flags; every other byte
   // consumes and clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ascii       <= '0;
         ascii_valid <= 1'b0;
         shift_on    <= 1'b0;
         brk         <= 1'b0;
         ext         <= 1'b0;
      end else begin
         ascii_valid <= 1'b0;
         if (scan_done) begin
            if (scan_code == 8'hE0) begin
               ext <= 1'b1;
            end else if (scan_code == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               if ((scan_code == 8'h12 || scan_code == 8'h59) && !ext) begin
                  shift_on <= ~brk;
               end else if (!brk && !ext && hit) begin
                  ascii       <= map;
                  ascii_valid <= 1'b1;
               end
               brk <= 1'b0;
               ext <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_ascii_rx.sv
// tb/tb_ps2_ascii_rx.sv - self-checking bench for ps2_ascii_rx
module tb_ps2_ascii_rx;

   localparam int HALF    = 30;
   localparam int TIMEOUT = 1500;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2c = 1'b1;
   logic       ps2d = 1'b1;
   logic [7:0] ascii, scan_code;
   logic       ascii_valid, scan_done, frame_err, shift_on;

   int vectors = 0;
   int miscompares = 0;

   int         n_done = 0, n_err = 0, n_av = 0;
   logic [7:0] last_sc = 8'h00, last_ascii = 8'h00;
   logic       prev_done = 1'b0;

   bit m_brk, m_ext, m_shift;

   typedef struct {
      logic [7:0] code;
      bit         bad_par;
      bit         bad_stop;
      bit         exp_done;
      bit         exp_err;
      bit         exp_av;
      logic [7:0] exp_ascii;
      bit         exp_shift;
   } vec_t;

   vec_t tbl[$];

   logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
   logic [7:0] pool[16] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h1C, 8'h32, 8'h16, 8'h45,
      8'h46, 8'h29, 8'h5A, 8'h66, 8'h0E, 8'h75, 8'h1A, 8'h3E};
   string shifted_digits = ")!@#$%^&*(";

   ps2_ascii_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
      .ascii(ascii), .ascii_valid(ascii_valid), .scan_code(scan_code),
      .scan_done(scan_done), .frame_err(frame_err), .shift_on(shift_on)
   );

   always #20 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (scan_done || frame_err)
            check("done_err_exclusive", int'(scan_done & frame_err), 0);
         if (ascii_valid) begin
            check("ascii_latency", int'(prev_done), 1);
            n_av++;
            last_ascii = ascii;
         end
         if (scan_done) begin
            n_done++;
            last_sc = scan_code;
         end
         if (frame_err)
            n_err++;
      end
      prev_done = scan_done;
   end

   // Spec-level character lookup: position in the letter/digit lists.
   task automatic lookup(input logic [7:0] c, input bit sh, output bit hit, output logic [7:0] a);
      hit = 1'b0;
      a   = 8'h00;
      for (int i = 0; i < 26; i++)
         if (letter_codes[i] == c) begin
            hit = 1'b1;
            a   = sh ? 8'(8'h41 + i) : 8'(8'h61 + i);
         end
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == c) begin
            hit = 1'b1;
            a   = sh ? shifted_digits[i] : 8'(8'h30 + i);
         end
      if (c == 8'h29) begin hit = 1'b1; a = 8'h20; end
      if (c == 8'h5A) begin hit = 1'b1; a = 8'h0D; end
      if (c == 8'h66) begin hit = 1'b1; a = 8'h08; end
   endtask

   task automatic model_step(input logic [7:0] c, output bit av, output logic [7:0] a);
      bit hit;
      av = 1'b0;
      lookup(c, m_shift, hit, a);
      if (c == 8'hE0)
         m_ext = 1'b1;
      else if (c == 8'hF0)
         m_brk = 1'b1;
      else begin
         if ((c == 8'h12 || c == 8'h59) && !m_ext)
            m_shift = !m_brk;
         else
            av = hit && !m_brk && !m_ext;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic clk_bit(input bit v, input bit glitch);
      ps2d = v;
      repeat (10) @(posedge clk);
      if (glitch) begin
         ps2c = 1'b0;
         repeat (2) @(posedge clk);
         ps2c = 1'b1;
         repeat (HALF - 12) @(posedge clk);
      end else
         repeat (HALF - 10) @(posedge clk);
      ps2c = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
      clk_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++)
         clk_bit(b[i], glitch);
      clk_bit((~^b) ^ bad_par, glitch);
      clk_bit(~bad_stop, glitch);
      ps2d = 1'b1;
      repeat (40) @(posedge clk);
   endtask

   task automatic apply_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit exp_done, input bit exp_err,
                              input bit exp_av, input logic [7:0] exp_ascii, input bit exp_shift);
      int d0, e0, a0;
      d0 = n_done; e0 = n_err; a0 = n_av;
      send_frame(code, bad_par, bad_stop, glitch);
      check("scan_done_count", n_done - d0, int'(exp_done));
      check("frame_err_count", n_err - e0, int'(exp_err));
      check("ascii_valid_count", n_av - a0, int'(exp_av));
      if (exp_done)
         check("scan_code", int'(last_sc), int'(code));
      if (exp_av)
         check("ascii", int'(last_ascii), int'(exp_ascii));
      check("shift_on", int'(shift_on), int'(exp_shift));
   endtask

   task automatic check_reset_state();
      check("rst_ascii", int'(ascii), 0);
      check("rst_ascii_valid", int'(ascii_valid), 0);
      check("rst_scan_code", int'(scan_code), 0);
      check("rst_scan_done", int'(scan_done), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_shift_on", int'(shift_on), 0);
   endtask

   initial begin
      int d0, e0, a0;
      bit av, bp;
      logic [7:0] a, c;

      //           code   bp bs dn er av ascii  sh
      tbl.push_back('{8'h1C, 0, 0, 1, 0, 1, 8'h61, 0});
      tbl.push_back('{8'h12, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'h1C, 0, 0, 1, 0, 1, 8'h41, 1});
      tbl.push_back('{8'hF0, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'h1C, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'hF0, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'h12, 0, 0, 1, 0, 0, 8'h00, 0});
      tbl.push_back('{8'h1C, 0, 0, 1, 0, 1, 8'h61, 0});
      tbl.push_back('{8'h16, 1, 0, 0, 1, 0, 8'h00, 0});
      tbl.push_back('{8'h29, 0, 0, 1, 0, 1, 8'h20, 0});
      tbl.push_back('{8'hE0, 0, 0, 1, 0, 0, 8'h00, 0});
      tbl.push_back('{8'h75, 0, 0, 1, 0, 0, 8'h00, 0});
      tbl.push_back('{8'h45, 0, 0, 1, 0, 1, 8'h30, 0});
      tbl.push_back('{8'h66, 0, 1, 0, 1, 0, 8'h00, 0});
      tbl.push_back('{8'h59, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'h16, 0, 0, 1, 0, 1, 8'h21, 1});
      tbl.push_back('{8'h46, 0, 0, 1, 0, 1, 8'h28, 1});
      tbl.push_back('{8'h3E, 0, 0, 1, 0, 1, 8'h2A, 1});
      tbl.push_back('{8'hE0, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'h12, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'hF0, 0, 0, 1, 0, 0, 8'h00, 1});
      tbl.push_back('{8'h59, 0, 0, 1, 0, 0, 8'h00, 0});
      tbl.push_back('{8'h5A, 0, 0, 1, 0, 1, 8'h0D, 0});
      tbl.push_back('{8'hF0, 0, 0, 1, 0, 0, 8'h00, 0});
      tbl.push_back('{8'h1C, 1, 0, 0, 1, 0, 8'h00, 0});
      tbl.push_back('{8'h1C, 0, 0, 1, 0, 0, 8'h00, 0});
      tbl.push_back('{8'h2B, 0, 0, 1, 0, 1, 8'h66, 0});
      tbl.push_back('{8'h0E, 0, 0, 1, 0, 0, 8'h00, 0});
      tbl.push_back('{8'h1A, 0, 0, 1, 0, 1, 8'h7A, 0});
      tbl.push_back('{8'h1A, 0, 0, 1, 0, 1, 8'h7A, 0});

      repeat (5) @(posedge clk);
      #1 check_reset_state();
      rst = 1'b0;
      repeat (20) @(posedge clk);
      check_reset_state();

      foreach (tbl[i])
         apply_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, 1'b0, tbl[i].exp_done,
                     tbl[i].exp_err, tbl[i].exp_av, tbl[i].exp_ascii, tbl[i].exp_shift);

      // Timeout: start bit plus 5 data bits, then the clock stays high.
      d0 = n_done; e0 = n_err; a0 = n_av;
      clk_bit(1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         clk_bit(1'($urandom_range(0, 1)), 1'b0);
      ps2d = 1'b1;
      repeat (TIMEOUT + 500) @(posedge clk);
      check("timeout_err", n_err - e0, 1);
      check("timeout_done", n_done - d0, 0);
      check("timeout_av", n_av - a0, 0);
      apply_frame(8'h5A, 0, 0, 0, 1, 0, 1, 8'h0D, 0);

      // Short clock glitches while idle, then inside every bit of a frame.
      d0 = n_done; e0 = n_err;
      for (int i = 0; i < 4; i++) begin
         ps2c = 1'b0;
         repeat (2) @(posedge clk);
         ps2c = 1'b1;
         repeat (15) @(posedge clk);
      end
      repeat (20) @(posedge clk);
      check("idle_glitch_done", n_done - d0, 0);
      check("idle_glitch_err", n_err - e0, 0);
      apply_frame(8'h45, 0, 0, 1, 1, 0, 1, 8'h30, 0);

      // Reset in the middle of a 66 frame with shift held, then resend.
      apply_frame(8'h12, 0, 0, 0, 1, 0, 0, 8'h00, 1);
      clk_bit(1'b0, 1'b0);
      clk_bit(1'b0, 1'b0);
      clk_bit(1'b1, 1'b0);
      clk_bit(1'b1, 1'b0);
      ps2c = 1'b0;
      repeat (HALF / 2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      ps2c = 1'b1;
      ps2d = 1'b1;
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      check_reset_state();
      apply_frame(8'h66, 0, 0, 0, 1, 0, 1, 8'h08, 0);

      // Randomised frames against the reference model.
      m_brk = 1'b0; m_ext = 1'b0; m_shift = 1'b0;
      for (int n = 0; n < 30; n++) begin
         c  = pool[$urandom_range(0, 15)];
         bp = ($urandom_range(0, 7) == 0);
         av = 1'b0;
         a  = 8'h00;
         if (!bp)
            model_step(c, av, a);
         apply_frame(c, bp, 0, 0, !bp, bp, av, a, m_shift);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
